// File: rtl/switch_debounce.sv
// Two-channel switch conditioner: synchronises, debounces and edge-detects raw switch levels.
// Optional macro SWITCH_DEBOUNCE_SYNC3_EN selects a three-flop synchroniser instead of two.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a_raw,
  input  logic sw_b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic changed,
  output logic stable
);

`ifdef SWITCH_DEBOUNCE_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("switch_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
  end

  logic [SYNC_N-1:0] sync_a_q;
  logic [SYNC_N-1:0] sync_b_q;
  logic              sync_a;
  logic              sync_b;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;

  assign sync_a = sync_a_q[SYNC_N-1];
  assign sync_b = sync_b_q[SYNC_N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_N-2:0], sw_a_raw};
      sync_b_q <= {sync_b_q[SYNC_N-2:0], sw_b_raw};
    end
  end

  // Any cycle where the synchronised level agrees with the output restarts the count,
  // so only an unbroken run of DEBOUNCE_CYCLES mismatches moves the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a  <= '0;
      a      <= 1'b0;
      a_rise <= 1'b0;
      a_fall <= 1'b0;
    end else begin
      a_rise <= 1'b0;
      a_fall <= 1'b0;
      if (sync_a == a) begin
        cnt_a <= '0;
      end else if (cnt_a == CNT_MAX) begin
        cnt_a  <= '0;
        a      <= sync_a;
        a_rise <= sync_a;
        a_fall <= ~sync_a;
      end else begin
        cnt_a <= cnt_a + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_b  <= '0;
      b      <= 1'b0;
      b_rise <= 1'b0;
      b_fall <= 1'b0;
    end else begin
      b_rise <= 1'b0;
      b_fall <= 1'b0;
      if (sync_b == b) begin
        cnt_b <= '0;
      end else if (cnt_b == CNT_MAX) begin
        cnt_b  <= '0;
        b      <= sync_b;
        b_rise <= sync_b;
        b_fall <= ~sync_b;
      end else begin
        cnt_b <= cnt_b + 1'b1;
      end
    end
  end

  assign changed = a_rise | a_fall | b_rise | b_fall;
  assign stable  = (sync_a == a) && (sync_b == b);

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce (DEBOUNCE_CYCLES=4, CNT_W=4); pulse events are
// predicted with their edge number and matched by an independent monitor.
module tb_switch_debounce;

  localparam int DC = 4;
`ifdef SWITCH_DEBOUNCE_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif
  localparam int LAT = DC + SYNC_N;
  localparam int W   = 21;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_a_raw, sw_b_raw;
  logic a, b, a_rise, a_fall, b_rise, b_fall, changed, stable;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // entry = {edge number[15:0], changed, a_rise, a_fall, b_rise, b_fall}
  logic [W-1:0] exp_q[$];

  switch_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_a_raw(sw_a_raw), .sw_b_raw(sw_b_raw),
    .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall),
    .changed(changed), .stable(stable)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after driving a new raw level: the update lands LAT edges later.
  task automatic push_evt(input logic ar, input logic af, input logic br, input logic bf);
    logic [15:0] at;
    at = 16'(cyc + LAT);
    exp_q.push_back({at, 1'b1, ar, af, br, bf});
  endtask

  task automatic check_levels(input string tag, input logic ea, input logic eb);
    check({tag, "_a"}, 32'(a), 32'(ea));
    check({tag, "_b"}, 32'(b), 32'(eb));
  endtask

  // monitor: every pulse cycle must match the head of the expected queue
  always begin
    logic [W-1:0] got, exp;
    @(posedge clk);
    #1;
    if (changed || a_rise || a_fall || b_rise || b_fall) begin
      got = {16'(cyc), changed, a_rise, a_fall, b_rise, b_fall};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(got), 32'(0));
      end else begin
        exp = exp_q.pop_front();
        check("pulse_event", 32'(got), 32'(exp));
      end
    end
  end

  initial begin
    // 1: reset with both raw inputs high, then release
    rst_n = 1'b0; sw_a_raw = 1'b1; sw_b_raw = 1'b1;
    tick(3);
    check_levels("rst", 1'b0, 1'b0);
    check("rst_pulses", 32'({a_rise, a_fall, b_rise, b_fall}), 32'(0));
    check("rst_changed", 32'(changed), 32'(0));
    check("rst_stable", 32'(stable), 32'(1));
    rst_n = 1'b1;
    push_evt(1'b1, 1'b0, 1'b1, 1'b0);
    tick(LAT + 2);
    check_levels("rel", 1'b1, 1'b1);
    check("rel_stable", 32'(stable), 32'(1));

    // drop A back to 0 so the clean step starts from a=0
    sw_a_raw = 1'b0;
    push_evt(1'b0, 1'b1, 1'b0, 1'b0);
    tick(LAT + 2);
    check_levels("afall", 1'b0, 1'b1);

    // 2: clean step on A, watching stable and a edge by edge
    sw_a_raw = 1'b1;
    push_evt(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(1);
      check($sformatf("step_stable_k%0d", k), 32'(stable),
            32'((k < SYNC_N || k >= LAT) ? 1 : 0));
      check($sformatf("step_a_k%0d", k), 32'(a), 32'(k >= LAT ? 1 : 0));
      check($sformatf("step_b_k%0d", k), 32'(b), 32'(1));
    end

    // 3: fast toggling from a=0 never reaches the output
    sw_a_raw = 1'b0;
    push_evt(1'b0, 1'b1, 1'b0, 1'b0);
    tick(LAT + 2);
    for (int k = 0; k < 4; k++) begin
      sw_a_raw = (k % 2 == 0);
      tick(1);
    end
    sw_a_raw = 1'b0;
    tick(10);
    check_levels("toggle", 1'b0, 1'b1);

    // 4: bounce 1,1,1,0 then 1 held; only the final rising edge counts
    sw_a_raw = 1'b1;
    tick(3);
    sw_a_raw = 1'b0;
    tick(1);
    sw_a_raw = 1'b1;
    push_evt(1'b1, 1'b0, 1'b0, 1'b0);
    tick(LAT - 1);
    check("bounce_early_a", 32'(a), 32'(0));
    tick(3);
    check_levels("bounce", 1'b1, 1'b1);

    // 5: simultaneous fall on both channels
    sw_a_raw = 1'b0; sw_b_raw = 1'b0;
    push_evt(1'b0, 1'b1, 1'b0, 1'b1);
    tick(LAT + 2);
    check_levels("both_fall", 1'b0, 1'b0);

    // 5b: reset while B is mid-count abandons the update
    sw_b_raw = 1'b1;
    tick(SYNC_N + 1);
    rst_n = 1'b0;
    tick(1);
    check_levels("midrst", 1'b0, 1'b0);
    check("midrst_pulses", 32'({a_rise, a_fall, b_rise, b_fall}), 32'(0));
    check("midrst_changed", 32'(changed), 32'(0));
    check("midrst_stable", 32'(stable), 32'(1));
    sw_b_raw = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(LAT + 4);
    check_levels("post_rst", 1'b0, 1'b0);

    check("evt_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
